// File: rtl/wiphy_trx_ctrl.sv
// rtl/wiphy_trx_ctrl.sv - half-duplex TX/RX burst sequencer with turnaround guard
//
// Purpose:
//   Arbitrates transmit and receive burst requests, counts DAC/ADC sample
//   beats for the granted burst and enforces a fixed turnaround (GUARD)
//   period after every burst. All outputs are registered.
//
// Parameters:
//   GUARD    turnaround cycles after every burst (1..255)
//   TIMEOUT  stall-watchdog limit in cycles (used only with the option below)
//
// Optional feature:
//   WIPHY_TRX_CTRL_TIMEOUT_EN  when defined, a burst that sees TIMEOUT
//                              consecutive cycles without a beat ends with
//                              status[1]=1; when undefined no watchdog exists
//                              and status[1] is always 0.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   tx_req, tx_len      transmit request (level) and length in samples
//   tx_ack              one-cycle pulse when a TX burst is granted
//   rx_req, rx_len      receive request (level) and length in samples
//   rx_ack              one-cycle pulse when an RX burst is granted
//   dac_valid/ready     DAC handshake; a beat is valid & ready while in TX
//   adc_valid           ADC sample strobe; one beat per strobe while in RX
//   abort               ends the active burst early
//   tx_en, rx_en        DAC / ADC path enables
//   busy                state != IDLE
//   done                one-cycle pulse on entry to GUARD
//   status              {timeout, aborted} of the last burst
//   irq, irq_clr        sticky interrupt and its clear (set wins)
//   state               IDLE=0, TX=1, RX=2, GUARD=3

module wiphy_trx_ctrl #(
    parameter int GUARD   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_req,
    input  logic [15:0] tx_len,
    output logic        tx_ack,
    input  logic        rx_req,
    input  logic [15:0] rx_len,
    output logic        rx_ack,
    input  logic        dac_valid,
    input  logic        dac_ready,
    input  logic        adc_valid,
    input  logic        abort,
    output logic        tx_en,
    output logic        rx_en,
    output logic        busy,
    output logic        done,
    output logic [1:0]  status,
    output logic        irq,
    input  logic        irq_clr,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TX    = 3'd1,
        S_RX    = 3'd2,
        S_GUARD = 3'd3
    } state_t;

    if (GUARD < 1 || GUARD > 255 || TIMEOUT < 1) begin : g_param_check
        $error("wiphy_trx_ctrl: GUARD must be 1..255 and TIMEOUT >= 1");
    end

    localparam logic [7:0] GUARD_LD = 8'(GUARD - 1);

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [7:0]  gcnt_q;
    logic        tx_first_q;   // round-robin pointer: 1 = TX wins a tie
    logic        tx_ack_q;
    logic        rx_ack_q;
    logic        tx_en_q;
    logic        rx_en_q;
    logic        busy_q;
    logic        done_q;
    logic [1:0]  status_q;
    logic        irq_q;

    logic beat;
    logic complete;
    logic wd_fire;

    assign beat = (state_q == S_TX) ? (dac_valid & dac_ready) : adc_valid;

    // A zero-length burst completes after its single TX/RX cycle; a beat
    // with one sample left completes even if abort is also high.
    assign complete = (cnt_q == 16'd0) || (beat && (cnt_q == 16'd1));

`ifdef WIPHY_TRX_CTRL_TIMEOUT_EN
    logic [31:0] wd_q;   // consecutive beat-less cycles in the current burst
    assign wd_fire = !beat && (wd_q == 32'(TIMEOUT - 1));
`else
    assign wd_fire = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 16'd0;
            gcnt_q     <= 8'd0;
            tx_first_q <= 1'b1;
            tx_ack_q   <= 1'b0;
            rx_ack_q   <= 1'b0;
            tx_en_q    <= 1'b0;
            rx_en_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            status_q   <= 2'b00;
            irq_q      <= 1'b0;
`ifdef WIPHY_TRX_CTRL_TIMEOUT_EN
            wd_q       <= 32'd0;
`endif
        end else begin
            tx_ack_q <= 1'b0;
            rx_ack_q <= 1'b0;
            done_q   <= 1'b0;
            if (irq_clr) begin
                irq_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
`ifdef WIPHY_TRX_CTRL_TIMEOUT_EN
                    wd_q <= 32'd0;
`endif
                    if (tx_req && (!rx_req || tx_first_q)) begin
                        state_q    <= S_TX;
                        tx_en_q    <= 1'b1;
                        tx_ack_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        cnt_q      <= tx_len;
                        tx_first_q <= 1'b0;
                    end else if (rx_req) begin
                        state_q    <= S_RX;
                        rx_en_q    <= 1'b1;
                        rx_ack_q   <= 1'b1;
                        busy_q     <= 1'b1;
                        cnt_q      <= rx_len;
                        tx_first_q <= 1'b1;
                    end
                end

                S_TX, S_RX: begin
                    if (beat && (cnt_q != 16'd0)) begin
                        cnt_q <= cnt_q - 16'd1;
                    end
`ifdef WIPHY_TRX_CTRL_TIMEOUT_EN
                    wd_q <= beat ? 32'd0 : wd_q + 32'd1;
`endif
                    if (complete || abort || wd_fire) begin
                        state_q  <= S_GUARD;
                        tx_en_q  <= 1'b0;
                        rx_en_q  <= 1'b0;
                        done_q   <= 1'b1;
                        irq_q    <= 1'b1;   // after irq_clr above: set wins
                        gcnt_q   <= GUARD_LD;
                        status_q <= {!complete && !abort && wd_fire,
                                     !complete && abort};
                    end
                end

                S_GUARD: begin
                    if (gcnt_q == 8'd0) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gcnt_q <= gcnt_q - 8'd1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    tx_en_q <= 1'b0;
                    rx_en_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ack = tx_ack_q;
    assign rx_ack = rx_ack_q;
    assign tx_en  = tx_en_q;
    assign rx_en  = rx_en_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign status = status_q;
    assign irq    = irq_q;
    assign state  = state_q;

endmodule

// File: tb/tb_wiphy_trx_ctrl.sv
// tb/tb_wiphy_trx_ctrl.sv - self-checking bench for wiphy_trx_ctrl

module tb_wiphy_trx_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tx_req = 1'b0;
    logic [15:0] tx_len = 16'd0;
    logic        tx_ack;
    logic        rx_req = 1'b0;
    logic [15:0] rx_len = 16'd0;
    logic        rx_ack;
    logic        dac_valid = 1'b0;
    logic        dac_ready = 1'b0;
    logic        adc_valid = 1'b0;
    logic        abort = 1'b0;
    logic        tx_en;
    logic        rx_en;
    logic        busy;
    logic        done;
    logic [1:0]  status;
    logic        irq;
    logic        irq_clr = 1'b0;
    logic [2:0]  state;

    wiphy_trx_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .tx_req    (tx_req),
        .tx_len    (tx_len),
        .tx_ack    (tx_ack),
        .rx_req    (rx_req),
        .rx_len    (rx_len),
        .rx_ack    (rx_ack),
        .dac_valid (dac_valid),
        .dac_ready (dac_ready),
        .adc_valid (adc_valid),
        .abort     (abort),
        .tx_en     (tx_en),
        .rx_en     (rx_en),
        .busy      (busy),
        .done      (done),
        .status    (status),
        .irq       (irq),
        .irq_clr   (irq_clr),
        .state     (state)
    );

    always #5 clk = ~clk;

    localparam int BUDGET = 3000;

    typedef struct {
        bit          is_tx;
        logic [15:0] len;
        int          gap;          // leading burst cycles with no sample offered
        int          abort_at;     // burst cycle carrying abort (0 = never)
        bit          abort_valid;  // sample offered in the abort cycle
        int          exp_en;       // expected cycles with the path enabled
        logic [1:0]  exp_st;       // expected status
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        vec_t e;
        int   en_cnt, ack_ok, ack_bad, done_cnt, g_cnt, cyc;
        bit   started, bad_en, en_now, val, finished;
        logic [1:0] st_seen;
        logic       irq_seen;
        en_cnt = 0; ack_ok = 0; ack_bad = 0; done_cnt = 0; g_cnt = 0; cyc = 0;
        started = 0; bad_en = 0; finished = 0; st_seen = 2'b11; irq_seen = 1'b0;

        exp_q.push_back(v);
        @(negedge clk);
        if (v.is_tx) begin
            tx_req = 1'b1; tx_len = v.len;
        end else begin
            rx_req = 1'b1; rx_len = v.len;
        end
        dac_valid = 1'b0; dac_ready = 1'b0; adc_valid = 1'b0; abort = 1'b0;

        while (cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            if (v.is_tx) begin
                if (tx_ack) ack_ok++;
                if (rx_ack) ack_bad++;
            end else begin
                if (rx_ack) ack_ok++;
                if (tx_ack) ack_bad++;
            end
            if (tx_ack || rx_ack) begin
                tx_req = 1'b0; rx_req = 1'b0;
            end
            if (tx_en && rx_en) bad_en = 1;
            if (tx_en !== (state == 3'd1) || rx_en !== (state == 3'd2)) bad_en = 1;
            if (done) begin
                done_cnt++; st_seen = status; irq_seen = irq;
            end
            if (state == 3'd3) g_cnt++;
            if (state != 3'd0) started = 1;
            en_now = v.is_tx ? tx_en : rx_en;
            if (en_now) en_cnt++;

            abort = 1'b0;
            val   = 1'b0;
            if (en_now) begin
                val = (en_cnt > v.gap);
                if (en_cnt == v.abort_at) begin
                    abort = 1'b1;
                    val   = v.abort_valid;
                end
            end
            dac_valid = val && v.is_tx;
            dac_ready = val && v.is_tx;
            adc_valid = val && !v.is_tx;
            if (started && state == 3'd0) begin
                finished = 1;
                break;
            end
        end
        tx_req = 1'b0; rx_req = 1'b0;

        e = exp_q.pop_front();
        chk({tag, " finished"},  32'(finished), 32'd1);
        chk({tag, " ack"},       32'(ack_ok), 32'd1);
        chk({tag, " wrong_ack"}, 32'(ack_bad), 32'd0);
        chk({tag, " en_cycles"}, 32'(en_cnt), 32'(e.exp_en));
        chk({tag, " en_rules"},  32'(bad_en), 32'd0);
        chk({tag, " done"},      32'(done_cnt), 32'd1);
        chk({tag, " status"},    32'(st_seen), 32'(e.exp_st));
        chk({tag, " irq"},       32'(irq_seen), 32'd1);
        chk({tag, " guard"},     32'(g_cnt), 32'd16);
    endtask

    initial begin
        int   acks[$];
        int   gruns[$];
        int   grun, tx_cyc, rx_cyc, overlap, done_cnt, rx_seen;
        bit   ok;

        //                is_tx len       gap   ab_at av  en    st
        tbl.push_back('{1'b1, 16'd4,     0,    0,    0,  4,    2'b00});
        tbl.push_back('{1'b0, 16'd8,     0,    4,    0,  4,    2'b01});
        tbl.push_back('{1'b1, 16'd0,     5,    0,    0,  1,    2'b00});
        tbl.push_back('{1'b0, 16'd0,     5,    0,    0,  1,    2'b00});
        tbl.push_back('{1'b1, 16'd3,     2,    0,    0,  5,    2'b00});
        tbl.push_back('{1'b1, 16'd3,     0,    3,    1,  3,    2'b00});
        tbl.push_back('{1'b1, 16'd3,     0,    2,    0,  2,    2'b01});
        tbl.push_back('{1'b0, 16'd1,     3,    0,    0,  4,    2'b00});
        tbl.push_back('{1'b1, 16'd65535, 0,    3,    0,  3,    2'b01});
`ifdef WIPHY_TRX_CTRL_TIMEOUT_EN
        tbl.push_back('{1'b1, 16'd4,     5000, 0,    0,  1024, 2'b10});
`endif

        // Outputs while reset is held
        @(negedge clk);
        @(negedge clk);
        chk("reset_outputs", 32'({tx_ack, rx_ack, tx_en, rx_en, busy, done, status, irq, state}), 32'd0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            run_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Aborted burst, then abort while idle must change nothing
        run_vec('{1'b1, 16'd5, 0, 1, 0, 1, 2'b01}, "abort_tx");
        done_cnt = 0;
        ok = 1;
        abort = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (state != 3'd0) ok = 0;
        end
        abort = 1'b0;
        chk("idle_abort_state", 32'(ok), 32'd1);
        chk("idle_abort_done", 32'(done_cnt), 32'd0);
        chk("idle_abort_status", 32'(status), 32'd1);

        // irq_clr alone clears; held across a set event, set wins
        irq_clr = 1'b1;
        @(negedge clk);
        chk("irq_clr_idle", 32'(irq), 32'd0);
        run_vec('{1'b1, 16'd1, 0, 0, 0, 1, 2'b00}, "irq_set_wins");
        chk("irq_cleared_after", 32'(irq), 32'd0);
        irq_clr = 1'b0;

        // Both requests held: TX, RX, TX with guards between
        do_reset();
        grun = 0; tx_cyc = 0; rx_cyc = 0; overlap = 0;
        tx_req = 1'b1; rx_req = 1'b1; tx_len = 16'd2; rx_len = 16'd2;
        dac_valid = 1'b1; dac_ready = 1'b1; adc_valid = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (tx_ack) acks.push_back(1);
            if (rx_ack) acks.push_back(2);
            if (tx_en && rx_en) overlap++;
            if (tx_en) tx_cyc++;
            if (rx_en) rx_cyc++;
            if (state == 3'd3) grun++;
            else if (grun != 0) begin
                gruns.push_back(grun);
                grun = 0;
            end
            if (acks.size() == 3 && (tx_ack || rx_ack)) begin
                tx_req = 1'b0; rx_req = 1'b0;
            end
            if (acks.size() >= 3 && gruns.size() >= 3) break;
        end
        dac_valid = 1'b0; dac_ready = 1'b0; adc_valid = 1'b0;
        chk("rr_grants", 32'(acks.size()), 32'd3);
        chk("rr_order", 32'(acks.size() == 3 && acks[0] == 1 && acks[1] == 2 && acks[2] == 1), 32'd1);
        chk("rr_guard_runs", 32'(gruns.size()), 32'd3);
        foreach (gruns[i]) chk($sformatf("rr_guard%0d", i), 32'(gruns[i]), 32'd16);
        chk("rr_overlap", 32'(overlap), 32'd0);
        chk("rr_tx_cycles", 32'(tx_cyc), 32'd4);
        chk("rr_rx_cycles", 32'(rx_cyc), 32'd2);

        // Reset mid-RX drops rx_en at once and emits no done
        chk("pre_reset_irq", 32'(irq), 32'd1);
        rx_req = 1'b1; rx_len = 16'd100; adc_valid = 1'b1;
        rx_seen = 0;
        for (int c = 0; c < 50 && rx_seen < 10; c++) begin
            @(negedge clk);
            if (rx_ack) rx_req = 1'b0;
            if (rx_en) rx_seen++;
        end
        rx_req = 1'b0;
        chk("mid_rx_reached", 32'(rx_seen), 32'd10);
        reset = 1'b1;
        #1;
        chk("async_rx_en", 32'(rx_en), 32'd0);
        chk("async_state", 32'(state), 32'd0);
        chk("async_irq", 32'(irq), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        done_cnt = 0;
        @(negedge clk);
        if (done) done_cnt++;
        reset = 1'b0;
        adc_valid = 1'b0;
        ok = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) done_cnt++;
            if (state != 3'd0 || rx_en) ok = 0;
        end
        chk("post_reset_done", 32'(done_cnt), 32'd0);
        chk("post_reset_idle", 32'(ok), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
